// File: rtl/periph_bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// periph_bus_pkg : access codes, GPIO map and lane helpers for periph_bus
// Rev 1.0
// ---------------------------------------------------------------------------
package periph_bus_pkg;

  localparam int DM_OP_W = 3;

  typedef enum logic [DM_OP_W-1:0] {
    DM_OP_WD = 3'd0,
    DM_OP_HS = 3'd1,
    DM_OP_HZ = 3'd2,
    DM_OP_BS = 3'd3,
    DM_OP_BZ = 3'd4
  } dm_op_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_GLB  = 2'd1,
    SRC_STK  = 2'd2,
    SRC_GPIO = 2'd3
  } src_e;

  localparam logic [15:0] GLB_BASE_DEF  = 16'h8000;
  localparam logic [15:0] STK_BASE_DEF  = 16'h8003;
  localparam logic [15:0] GPIO_BASE_DEF = 16'hbf80;

  localparam logic [7:0] GPIO_LED        = 8'h00;
  localparam logic [7:0] GPIO_SW         = 8'h04;
  localparam logic [7:0] GPIO_BTN        = 8'h08;
  localparam logic [7:0] GPIO_SEG_EN     = 8'h0C;
  localparam logic [7:0] GPIO_SEG_DIGITS = 8'h10;
  localparam logic [7:0] GPIO_KEYPAD     = 8'h14;
  localparam logic [7:0] GPIO_BTN_EDGE   = 8'h18;
  localparam logic [7:0] GPIO_BTN_IRQ_EN = 8'h1C;
  localparam logic [7:0] GPIO_STATUS     = 8'h20;
  localparam logic [7:0] GPIO_FAULT_ADDR = 8'h24;

  function automatic logic [3:0] lane_be(input logic [DM_OP_W-1:0] op, input logic [1:0] a);
    case (op)
      DM_OP_WD:           lane_be = 4'hF;
      DM_OP_HS, DM_OP_HZ: lane_be = a[1] ? 4'hC : 4'h3;
      DM_OP_BS, DM_OP_BZ: lane_be = 4'b0001 << a;
      default:            lane_be = 4'h0;
    endcase
  endfunction

  // Replicate the store LSBs onto every lane; the byte enables pick the target
  function automatic logic [31:0] lane_wdata(input logic [DM_OP_W-1:0] op, input logic [31:0] d);
    case (op)
      DM_OP_HS, DM_OP_HZ: lane_wdata = {2{d[15:0]}};
      DM_OP_BS, DM_OP_BZ: lane_wdata = {4{d[7:0]}};
      default:            lane_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [DM_OP_W-1:0] op, input logic [1:0] a,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (op)
      DM_OP_HS: load_extend = {{16{h[15]}}, h};
      DM_OP_HZ: load_extend = {16'h0000, h};
      DM_OP_BS: load_extend = {{24{b[7]}}, b};
      DM_OP_BZ: load_extend = {24'h000000, b};
      default:  load_extend = word;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/periph_bus_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// periph_bus_if : data-memory request/acknowledge bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface periph_bus_if;
  import periph_bus_pkg::*;

  logic               dm_req;
  logic               dm_w;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [DM_OP_W-1:0] dm_op;
  logic               dm_ack;
  logic [31:0]        rdata;
  logic               fault;

  modport master (output dm_req, dm_w, addr, wdata, dm_op, input dm_ack, rdata, fault);
  modport slave  (input dm_req, dm_w, addr, wdata, dm_op, output dm_ack, rdata, fault);
endinterface
`default_nettype wire

// File: rtl/periph_bus_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// periph_ram : word RAM with byte write enables and a registered read port
// Rev 1.0
// ---------------------------------------------------------------------------
module periph_ram
  import periph_bus_pkg::*;
#(
  parameter int WORDS = 1024,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[idx];
  end

endmodule
`default_nettype wire

// File: rtl/periph_bus.sv
`default_nettype none
// ---------------------------------------------------------------------------
// periph_bus : data-side slave decoding global RAM, stack RAM and GPIO
// Rev 1.0
// ---------------------------------------------------------------------------
module periph_bus
  import periph_bus_pkg::*;
#(
  parameter int          GLB_WORDS = 1024,
  parameter int          STK_WORDS = 1024,
  parameter logic [15:0] GLB_BASE  = GLB_BASE_DEF,
  parameter logic [15:0] STK_BASE  = STK_BASE_DEF,
  parameter logic [15:0] GPIO_BASE = GPIO_BASE_DEF,
  parameter int          N_LED     = 16,
  parameter int          N_SW      = 16,
  parameter int          N_PB      = 5
) (
  input  logic             clk,
  input  logic             rst,
  periph_bus_if.slave      bus,
  output logic             irq,
  output logic [N_LED-1:0] io_led,
  input  logic [N_SW-1:0]  io_switch,
  input  logic [N_PB-1:0]  io_btn,
  input  logic [3:0]       keypad_data,
  output logic [5:0]       seg_en,
  output logic [23:0]      seg_digits
);

  localparam int GLB_AW = $clog2(GLB_WORDS);
  localparam int STK_AW = $clog2(STK_WORDS);

  logic [DM_OP_W-1:0] op;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [7:0]         off;
  logic               unused_addr;

  assign op          = bus.dm_op;
  assign addr        = bus.addr;
  assign wdata       = bus.wdata;
  assign off         = addr[7:0];
  assign unused_addr = ^addr[15:8];

  logic hit_glb, hit_stk, hit_gpio;
  assign hit_glb  = addr[31:16] == GLB_BASE;
  assign hit_stk  = addr[31:16] == STK_BASE;
  assign hit_gpio = addr[31:16] == GPIO_BASE;

  logic op_ok, misaligned, off_ok, off_ro;
  always_comb begin
    op_ok      = 1'b1;
    misaligned = 1'b0;
    case (op)
      DM_OP_WD:           misaligned = addr[1:0] != 2'b00;
      DM_OP_HS, DM_OP_HZ: misaligned = addr[0];
      DM_OP_BS, DM_OP_BZ: misaligned = 1'b0;
      default:            op_ok = 1'b0;
    endcase
  end

  always_comb begin
    off_ok = 1'b1;
    off_ro = 1'b0;
    case (off)
      GPIO_LED, GPIO_SEG_EN, GPIO_SEG_DIGITS,
      GPIO_BTN_EDGE, GPIO_BTN_IRQ_EN, GPIO_STATUS:         off_ro = 1'b0;
      GPIO_SW, GPIO_BTN, GPIO_KEYPAD, GPIO_FAULT_ADDR:     off_ro = 1'b1;
      default:                                             off_ok = 1'b0;
    endcase
  end

  logic bad, take, accept, new_fault, gpio_wr;
  assign bad = !op_ok || misaligned || !(hit_glb || hit_stk || hit_gpio) ||
               (hit_gpio && (!off_ok || op != DM_OP_WD || (bus.dm_w && off_ro)));
  assign take      = bus.dm_req && !rst;
  assign accept    = take && !bad;
  assign new_fault = take && bad;
  assign gpio_wr   = accept && hit_gpio && bus.dm_w;

  logic [3:0]  be, glb_we, stk_we;
  logic        glb_re, stk_re;
  logic [31:0] wlanes, glb_rdata, stk_rdata;
  assign be     = lane_be(op, addr[1:0]);
  assign wlanes = lane_wdata(op, wdata);
  assign glb_we = (accept && hit_glb && bus.dm_w) ? be : 4'h0;
  assign stk_we = (accept && hit_stk && bus.dm_w) ? be : 4'h0;
  assign glb_re = accept && hit_glb && !bus.dm_w;
  assign stk_re = accept && hit_stk && !bus.dm_w;

  periph_ram #(.WORDS(GLB_WORDS)) u_glb_ram (
    .clk   (clk),
    .we    (glb_we),
    .re    (glb_re),
    .idx   (addr[GLB_AW+1:2]),
    .wdata (wlanes),
    .rdata (glb_rdata)
  );

  periph_ram #(.WORDS(STK_WORDS)) u_stk_ram (
    .clk   (clk),
    .we    (stk_we),
    .re    (stk_re),
    .idx   (addr[STK_AW+1:2]),
    .wdata (wlanes),
    .rdata (stk_rdata)
  );

  logic [N_SW-1:0]    sw_s1, sw_sync;
  logic [N_PB-1:0]    btn_s1, btn_sync, btn_prev, btn_edge, btn_irq_en, rise, edge_clr;
  logic               fault_sticky, sticky_clr;
  logic [31:0]        fault_addr, gpio_rd, gpio_rd_q;
  logic               ack_q, fault_q;
  src_e               src;
  logic [1:0]         lane_q;
  logic [DM_OP_W-1:0] op_q;

  always_comb begin
    gpio_rd = 32'h0;
    case (off)
      GPIO_LED:        gpio_rd = 32'(io_led);
      GPIO_SW:         gpio_rd = 32'(sw_sync);
      GPIO_BTN:        gpio_rd = 32'(btn_sync);
      GPIO_SEG_EN:     gpio_rd = {26'h0, seg_en};
      GPIO_SEG_DIGITS: gpio_rd = {8'h0, seg_digits};
      GPIO_KEYPAD:     gpio_rd = {28'h0, keypad_data};
      GPIO_BTN_EDGE:   gpio_rd = 32'(btn_edge);
      GPIO_BTN_IRQ_EN: gpio_rd = 32'(btn_irq_en);
      GPIO_STATUS:     gpio_rd = {31'h0, fault_sticky};
      GPIO_FAULT_ADDR: gpio_rd = fault_addr;
      default:         gpio_rd = 32'h0;
    endcase
  end

  assign rise       = btn_sync & ~btn_prev;
  assign edge_clr   = (gpio_wr && off == GPIO_BTN_EDGE) ? wdata[N_PB-1:0] : '0;
  assign sticky_clr = gpio_wr && off == GPIO_STATUS && wdata[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1        <= '0;
      sw_sync      <= '0;
      btn_s1       <= '0;
      btn_sync     <= '0;
      btn_prev     <= '0;
      btn_edge     <= '0;
      btn_irq_en   <= '0;
      fault_sticky <= 1'b0;
      fault_addr   <= 32'h0;
      io_led       <= '0;
      seg_en       <= 6'h3F;
      seg_digits   <= 24'h0;
      ack_q        <= 1'b0;
      fault_q      <= 1'b0;
      src          <= SRC_NONE;
      lane_q       <= 2'b00;
      op_q         <= '0;
      gpio_rd_q    <= 32'h0;
    end else begin
      sw_s1    <= io_switch;
      sw_sync  <= sw_s1;
      btn_s1   <= io_btn;
      btn_sync <= btn_s1;
      btn_prev <= btn_sync;
      ack_q    <= bus.dm_req;
      fault_q  <= new_fault;
      // A fresh edge or fault outranks a same-cycle clear
      btn_edge     <= (btn_edge & ~edge_clr) | rise;
      fault_sticky <= (fault_sticky & ~sticky_clr) | new_fault;
      if (new_fault) fault_addr <= addr;
      if (take) begin
        lane_q    <= addr[1:0];
        op_q      <= op;
        gpio_rd_q <= gpio_rd;
        if (bad || bus.dm_w) src <= SRC_NONE;
        else if (hit_glb)    src <= SRC_GLB;
        else if (hit_stk)    src <= SRC_STK;
        else                 src <= SRC_GPIO;
      end
      if (gpio_wr) begin
        case (off)
          GPIO_LED:        io_led     <= wdata[N_LED-1:0];
          GPIO_SEG_EN:     seg_en     <= wdata[5:0];
          GPIO_SEG_DIGITS: seg_digits <= wdata[23:0];
          GPIO_BTN_IRQ_EN: btn_irq_en <= wdata[N_PB-1:0];
          default: ;
        endcase
      end
    end
  end

  // Read data stays valid until the next ack because every source only moves on a request
  always_comb begin
    case (src)
      SRC_GLB:  bus.rdata = load_extend(op_q, lane_q, glb_rdata);
      SRC_STK:  bus.rdata = load_extend(op_q, lane_q, stk_rdata);
      SRC_GPIO: bus.rdata = gpio_rd_q;
      default:  bus.rdata = 32'h0;
    endcase
  end

  assign bus.dm_ack = ack_q;
  assign bus.fault  = fault_q;
  assign irq        = |(btn_edge & btn_irq_en);

endmodule
`default_nettype wire

// File: tb/tb_periph_bus.sv
`default_nettype none
// Directed self-checking bench for periph_bus: lanes, handshake, faults, GPIO, buttons, reset.
module tb_periph_bus;
  import periph_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq;
  logic [15:0] io_led;
  logic [15:0] io_switch = 16'h0;
  logic [4:0]  io_btn = 5'h0;
  logic [3:0]  keypad_data = 4'h9;
  logic [5:0]  seg_en;
  logic [23:0] seg_digits;

  int errors = 0;
  int checks = 0;

  logic        ack, flt;
  logic [31:0] rd;

  periph_bus_if bus ();

  periph_bus dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .irq         (irq),
    .io_led      (io_led),
    .io_switch   (io_switch),
    .io_btn      (io_btn),
    .keypad_data (keypad_data),
    .seg_en      (seg_en),
    .seg_digits  (seg_digits)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic access(input logic w, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, output logic o_ack, output logic [31:0] o_rd,
                        output logic o_flt);
    @(negedge clk);
    bus.dm_req = 1'b1; bus.dm_w = w; bus.dm_op = op; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    o_ack = bus.dm_ack; o_rd = bus.rdata; o_flt = bus.fault;
    bus.dm_req = 1'b0; bus.dm_w = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({bus.dm_ack, bus.fault} !== 2'b00) begin errors++; $display("FAIL reset_ack_fault: got %b want 00", {bus.dm_ack, bus.fault}); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    checks++; if ({io_led, seg_en, seg_digits, irq} !== {16'h0, 6'h3F, 24'h0, 1'b0}) begin errors++; $display("FAIL reset_gpio: led=%h seg_en=%h dig=%h irq=%b", io_led, seg_en, seg_digits, irq); end
    rst = 1'b0;
    access(1'b0, DM_OP_WD, 32'hbf800020, 0, ack, rd, flt);
    checks++; if ({ack, flt, rd} !== {2'b10, 32'h0}) begin errors++; $display("FAIL reset_status: ack=%b fault=%b rd=%h want 1 0 0", ack, flt, rd); end
    access(1'b0, DM_OP_WD, 32'hbf800024, 0, ack, rd, flt);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_fault_addr: got %h want 0", rd); end
  endtask

  task automatic test_lanes();
    access(1'b1, DM_OP_WD, 32'h80000010, 32'h11223344, ack, rd, flt);
    checks++; if ({ack, flt} !== 2'b10) begin errors++; $display("FAIL sw_ack: ack=%b fault=%b want 1 0", ack, flt); end
    access(1'b1, DM_OP_BS, 32'h80000011, 32'h000000AA, ack, rd, flt);
    access(1'b0, DM_OP_WD, 32'h80000010, 0, ack, rd, flt);
    checks++; if (rd !== 32'h1122AA44) begin errors++; $display("FAIL lw_after_sb: got %h want 1122aa44", rd); end
    access(1'b0, DM_OP_BS, 32'h80000011, 0, ack, rd, flt);
    checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb: got %h want ffffffaa", rd); end
    access(1'b0, DM_OP_BZ, 32'h80000011, 0, ack, rd, flt);
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL lbu: got %h want 000000aa", rd); end
    access(1'b0, DM_OP_HZ, 32'h80000012, 0, ack, rd, flt);
    checks++; if (rd !== 32'h00001122) begin errors++; $display("FAIL lhu: got %h want 00001122", rd); end
    access(1'b1, DM_OP_HZ, 32'h80000012, 32'hFFFF8001, ack, rd, flt);
    access(1'b0, DM_OP_HS, 32'h80000012, 0, ack, rd, flt);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_after_sh: got %h want ffff8001", rd); end
    access(1'b0, DM_OP_WD, 32'h80000010, 0, ack, rd, flt);
    checks++; if (rd !== 32'h8001AA44) begin errors++; $display("FAIL lw_after_sh: got %h want 8001aa44", rd); end
  endtask

  task automatic test_back_to_back();
    access(1'b1, DM_OP_WD, 32'h80000000, 32'h01020304, ack, rd, flt);
    @(negedge clk);
    bus.dm_req = 1'b1; bus.dm_w = 1'b1; bus.dm_op = DM_OP_WD; bus.addr = 32'h80030000; bus.wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (bus.dm_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1: got %b want 1", bus.dm_ack); end
    bus.dm_w = 1'b0;
    @(negedge clk);
    checks++; if ({bus.dm_ack, bus.fault, bus.rdata} !== {2'b10, 32'hDEADBEEF}) begin errors++; $display("FAIL b2b_read: ack=%b fault=%b rd=%h want 1 0 deadbeef", bus.dm_ack, bus.fault, bus.rdata); end
    bus.dm_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.dm_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_drop: got %b want 0", bus.dm_ack); end
    access(1'b0, DM_OP_WD, 32'h80000000, 0, ack, rd, flt);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL glb_independent: got %h want 01020304", rd); end
    access(1'b0, DM_OP_WD, 32'h80031000, 0, ack, rd, flt);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL stk_wrap: got %h want deadbeef", rd); end
  endtask

  task automatic test_faults();
    access(1'b0, DM_OP_WD, 32'h80000002, 0, ack, rd, flt);
    checks++; if ({ack, flt, rd} !== {2'b11, 32'h0}) begin errors++; $display("FAIL misaligned_lw: ack=%b fault=%b rd=%h want 1 1 0", ack, flt, rd); end
    access(1'b0, DM_OP_WD, 32'hbf800020, 0, ack, rd, flt);
    checks++; if ({flt, rd} !== {1'b0, 32'h1}) begin errors++; $display("FAIL status_set: fault=%b rd=%h want 0 1", flt, rd); end
    access(1'b0, DM_OP_WD, 32'hbf800024, 0, ack, rd, flt);
    checks++; if (rd !== 32'h80000002) begin errors++; $display("FAIL fault_addr: got %h want 80000002", rd); end
    access(1'b1, DM_OP_WD, 32'hbf800004, 32'hFFFF, ack, rd, flt);
    checks++; if (flt !== 1'b1) begin errors++; $display("FAIL ro_write: fault=%b want 1", flt); end
    access(1'b0, DM_OP_WD, 32'hbf800004, 0, ack, rd, flt);
    checks++; if ({flt, rd} !== {1'b0, 32'h0}) begin errors++; $display("FAIL sw_unaffected: fault=%b rd=%h want 0 0", flt, rd); end
    access(1'b1, DM_OP_WD, 32'h80000011, 32'hFFFFFFFF, ack, rd, flt);
    checks++; if (flt !== 1'b1) begin errors++; $display("FAIL misaligned_sw: fault=%b want 1", flt); end
    access(1'b0, DM_OP_WD, 32'h80000010, 0, ack, rd, flt);
    checks++; if (rd !== 32'h8001AA44) begin errors++; $display("FAIL suppressed_write: got %h want 8001aa44", rd); end
    access(1'b0, DM_OP_WD, 32'h12340000, 0, ack, rd, flt);
    checks++; if (flt !== 1'b1) begin errors++; $display("FAIL unmapped: fault=%b want 1", flt); end
    access(1'b0, 3'd7, 32'h80000010, 0, ack, rd, flt);
    checks++; if ({flt, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL bad_op: fault=%b rd=%h want 1 0", flt, rd); end
    access(1'b0, DM_OP_BZ, 32'hbf800000, 0, ack, rd, flt);
    checks++; if (flt !== 1'b1) begin errors++; $display("FAIL gpio_byte: fault=%b want 1", flt); end
    access(1'b0, DM_OP_WD, 32'hbf800028, 0, ack, rd, flt);
    checks++; if (flt !== 1'b1) begin errors++; $display("FAIL gpio_bad_off: fault=%b want 1", flt); end
    access(1'b0, DM_OP_WD, 32'hbf800024, 0, ack, rd, flt);
    checks++; if (rd !== 32'hbf800028) begin errors++; $display("FAIL fault_addr_latest: got %h want bf800028", rd); end
    access(1'b1, DM_OP_WD, 32'hbf800020, 32'h1, ack, rd, flt);
    access(1'b0, DM_OP_WD, 32'hbf800020, 0, ack, rd, flt);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL status_w1c: got %h want 0", rd); end
  endtask

  task automatic test_gpio();
    logic [31:0] r1, r2, r3;
    access(1'b1, DM_OP_WD, 32'hbf800000, 32'h000000A5, ack, rd, flt);
    checks++; if ({flt, io_led} !== {1'b0, 16'h00A5}) begin errors++; $display("FAIL led_port: fault=%b led=%h want 0 00a5", flt, io_led); end
    access(1'b1, DM_OP_WD, 32'hbf80000C, 32'hFFFFFF00, ack, rd, flt);
    access(1'b0, DM_OP_WD, 32'hbf80000C, 0, ack, rd, flt);
    checks++; if ({rd, seg_en} !== {32'h0, 6'h00}) begin errors++; $display("FAIL seg_en: rd=%h port=%h want 0 0", rd, seg_en); end
    access(1'b1, DM_OP_WD, 32'hbf800010, 32'hFF123456, ack, rd, flt);
    access(1'b0, DM_OP_WD, 32'hbf800010, 0, ack, rd, flt);
    checks++; if ({rd, seg_digits} !== {32'h00123456, 24'h123456}) begin errors++; $display("FAIL seg_digits: rd=%h port=%h want 00123456", rd, seg_digits); end
    access(1'b0, DM_OP_WD, 32'hbf800014, 0, ack, rd, flt);
    checks++; if (rd !== 32'h9) begin errors++; $display("FAIL keypad: got %h want 9", rd); end
    @(negedge clk);
    io_switch = 16'h1234;
    bus.dm_req = 1'b1; bus.dm_w = 1'b0; bus.dm_op = DM_OP_WD; bus.addr = 32'hbf800004;
    @(negedge clk); r1 = bus.rdata;
    @(negedge clk); r2 = bus.rdata;
    @(negedge clk); r3 = bus.rdata;
    bus.dm_req = 1'b0;
    checks++; if ({r1, r2, r3} !== {32'h0, 32'h0, 32'h1234}) begin errors++; $display("FAIL sw_sync: got %h %h %h want 0 0 1234", r1, r2, r3); end
  endtask

  task automatic test_buttons();
    access(1'b1, DM_OP_WD, 32'hbf80001C, 32'h1, ack, rd, flt);
    io_btn = 5'h01;
    repeat (4) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
    access(1'b0, DM_OP_WD, 32'hbf800018, 0, ack, rd, flt);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL btn_edge: got %h want 1", rd); end
    access(1'b0, DM_OP_WD, 32'hbf800008, 0, ack, rd, flt);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL btn_level: got %h want 1", rd); end
    access(1'b1, DM_OP_WD, 32'hbf800018, 32'h1, ack, rd, flt);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
    io_btn = 5'h00;
    repeat (4) @(negedge clk);
    io_btn = 5'h01;
    @(negedge clk);
    access(1'b1, DM_OP_WD, 32'hbf800018, 32'h1, ack, rd, flt);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq: got %b want 1", irq); end
    access(1'b0, DM_OP_WD, 32'hbf800018, 0, ack, rd, flt);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL set_wins_edge: got %h want 1", rd); end
    access(1'b1, DM_OP_WD, 32'hbf800018, 32'h1, ack, rd, flt);
    access(1'b0, DM_OP_WD, 32'hbf800018, 0, ack, rd, flt);
    checks++; if ({rd, irq} !== {32'h0, 1'b0}) begin errors++; $display("FAIL final_w1c: edge=%h irq=%b want 0 0", rd, irq); end
  endtask

  task automatic test_reset_mid_access();
    access(1'b1, DM_OP_WD, 32'h80000020, 32'h00000055, ack, rd, flt);
    @(negedge clk);
    rst = 1'b1;
    bus.dm_req = 1'b1; bus.dm_w = 1'b1; bus.dm_op = DM_OP_WD; bus.addr = 32'h80000020; bus.wdata = 32'h99;
    @(negedge clk);
    checks++; if (bus.dm_ack !== 1'b0) begin errors++; $display("FAIL rst_no_ack: got %b want 0", bus.dm_ack); end
    bus.dm_req = 1'b0; bus.dm_w = 1'b0;
    rst = 1'b0;
    checks++; if ({io_led, seg_en} !== {16'h0, 6'h3F}) begin errors++; $display("FAIL rst_gpio: led=%h seg_en=%h want 0 3f", io_led, seg_en); end
    access(1'b0, DM_OP_WD, 32'h80000020, 0, ack, rd, flt);
    checks++; if (rd !== 32'h00000055) begin errors++; $display("FAIL rst_no_write: got %h want 55", rd); end
  endtask

  initial begin
    bus.dm_req = 1'b0; bus.dm_w = 1'b0; bus.dm_op = DM_OP_WD; bus.addr = 32'h0; bus.wdata = 32'h0;
    test_reset();
    test_lanes();
    test_back_to_back();
    test_faults();
    test_gpio();
    test_buttons();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
